// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared types, obs bit indices and reference function for gate_logic_checker
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam int AND_B  = 6;
  localparam int OR_B   = 5;
  localparam int NAND_B = 4;
  localparam int NOR_B  = 3;
  localparam int NOTB_B = 2;
  localparam int XOR_B  = 1;
  localparam int XNOR_B = 0;

  function automatic logic [6:0] gate_expected(input logic a, input logic b);
    logic [6:0] e;
    e         = '0;
    e[AND_B]  = a & b;
    e[OR_B]   = a | b;
    e[NAND_B] = ~(a & b);
    e[NOR_B]  = ~(a | b);
    e[NOTB_B] = ~b;
    e[XOR_B]  = a ^ b;
    e[XNOR_B] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// rtl/gate_golden_model.sv - combinational reference: a,b -> expected seven gate outputs
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] expected
);

  assign expected = gate_expected(a, b);

endmodule

// File: rtl/gate_logic_checker.sv
// rtl/gate_logic_checker.sv - run FSM, counters, coverage and verdict for gate_logic responses
// Optional first-mismatch capture ports enabled by GATE_CHK_FIRSTFAIL_EN.
module gate_logic_checker
  import gate_chk_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int EXP_VEC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             a,
  input  logic             b,
  input  logic [6:0]       obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov
`ifdef GATE_CHK_FIRSTFAIL_EN
  ,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [6:0]       fail_mask
`endif
);

  chk_state_t state_q, state_d;
  logic [6:0] expected;
  logic       accept;
  logic       clear;
  logic       last;
  logic       mismatch;
  logic [3:0] cov_hit;

  gate_golden_model u_golden (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  assign mismatch = (obs != expected);
  assign cov_hit  = 4'b0001 << {a, b};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    clear   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // start wins over a coincident sample: clear only, nothing accepted
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (smp_valid) begin
          accept = 1'b1;
          if (vec_cnt == CNT_W'(EXP_VEC - 1)) begin
            last    = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      vec_cnt <= '0;
      err_cnt <= '0;
      cov     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      if (clear) begin
        pass    <= 1'b0;
        vec_cnt <= '0;
        err_cnt <= '0;
        cov     <= '0;
      end else if (accept) begin
        vec_cnt <= vec_cnt + 1'b1;
        err_cnt <= err_cnt + CNT_W'(mismatch);
        cov     <= cov | cov_hit;
        // verdict folds in the final sample, whose counter update lands this same edge
        if (last)
          pass <= (err_cnt == '0) && !mismatch && ((cov | cov_hit) == 4'hF);
      end
    end
  end

`ifdef GATE_CHK_FIRSTFAIL_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_mask  <= '0;
    end else if (accept && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= {a, b};
      fail_mask  <= obs ^ expected;
    end
  end
`endif

endmodule

// File: tb/tb_gate_logic_checker.sv
// tb/tb_gate_logic_checker.sv - directed self-checking bench for gate_logic_checker
module tb_gate_logic_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       smp_valid = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [6:0] obs = '0;
  logic       busy, done, pass;
  logic [7:0] vec_cnt, err_cnt;
  logic [3:0] cov;
`ifdef GATE_CHK_FIRSTFAIL_EN
  logic       fail_valid;
  logic [1:0] fail_vec;
  logic [6:0] fail_mask;
`endif

  int total = 0;
  int bad   = 0;
  // hand-computed {and,or,nand,nor,notb,xor,xnor} per {a,b}
  logic [6:0] good [4];

  gate_logic_checker #(.CNT_W(8), .EXP_VEC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .smp_valid (smp_valid),
    .a         (a),
    .b         (b),
    .obs       (obs),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .vec_cnt   (vec_cnt),
    .err_cnt   (err_cnt),
    .cov       (cov)
`ifdef GATE_CHK_FIRSTFAIL_EN
    ,
    .fail_valid(fail_valid),
    .fail_vec  (fail_vec),
    .fail_mask (fail_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic sample(input logic [1:0] ab, input logic [6:0] o);
    {a, b}    = ab;
    obs       = o;
    smp_valid = 1'b1;
    tick(1);
    smp_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic bz, input logic dn, input logic ps,
                              input logic [7:0] vc, input logic [7:0] ec, input logic [3:0] cv);
    check({tag, "_busy"}, busy, bz);
    check({tag, "_done"}, done, dn);
    check({tag, "_pass"}, pass, ps);
    check({tag, "_vec"},  vec_cnt, vc);
    check({tag, "_err"},  err_cnt, ec);
    check({tag, "_cov"},  cov, cv);
  endtask

  initial begin
    good[0] = 7'h1D;
    good[1] = 7'h32;
    good[2] = 7'h36;
    good[3] = 7'h61;

    tick(1);
    do_reset();
    check_status("rst", 0, 0, 0, 0, 0, 4'h0);
`ifdef GATE_CHK_FIRSTFAIL_EN
    check("rst_fv", fail_valid, 0);
`endif

    // 1: full correct sweep
    pulse_start();
    check("t1_busy0", busy, 1);
    for (int i = 0; i < 4; i++) sample(2'(i), good[i]);
    check_status("t1", 0, 1, 1, 4, 0, 4'hF);

    // 6: restart from DONE clears everything
    pulse_start();
    check_status("t6", 1, 0, 0, 0, 0, 4'h0);

    // 2: xor bit wrong on {1,1}
    for (int i = 0; i < 3; i++) sample(2'(i), good[i]);
    check("t2_nodone3", done, 0);
    sample(2'b11, 7'h63);
    check_status("t2", 0, 1, 0, 4, 1, 4'hF);
`ifdef GATE_CHK_FIRSTFAIL_EN
    check("t2_fv",   fail_valid, 1);
    check("t2_fvec", fail_vec, 2'b11);
    check("t2_fmsk", fail_mask, 7'b0000010);
    pulse_start();
    check("t6_fv",   fail_valid, 0);
    check("t6_fmsk", fail_mask, 0);
`else
    pulse_start();
`endif

    // 3: coverage hole
    for (int i = 0; i < 4; i++) sample(2'b00, good[0]);
    check_status("t3", 0, 1, 0, 4, 0, 4'b0001);

    // 4: reset mid-run
    pulse_start();
    sample(2'b01, good[1]);
    sample(2'b10, 7'h00);
    check("t4_vec_pre", vec_cnt, 2);
    check("t4_err_pre", err_cnt, 1);
    do_reset();
    check_status("t4", 0, 0, 0, 0, 0, 4'h0);
    sample(2'b11, good[3]);
    sample(2'b00, good[0]);
    check("t4_idle_vec", vec_cnt, 0);
    check("t4_idle_cov", cov, 0);

    // 5: start+smp_valid in IDLE, gaps, start in RUN
    {a, b} = 2'b11;
    obs = good[3];
    smp_valid = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    smp_valid = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_vec0", vec_cnt, 0);
    check("t5_cov0", cov, 0);
    tick(2);
    sample(2'b00, good[0]);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t5_startrun_vec", vec_cnt, 1);
    check("t5_startrun_busy", busy, 1);
    sample(2'b01, good[1]);
    tick(3);
    sample(2'b10, good[2]);
    check_status("t5_3", 1, 0, 0, 3, 0, 4'b0111);
    sample(2'b11, good[3]);
    check_status("t5_end", 0, 1, 1, 4, 0, 4'hF);
    sample(2'b00, 7'h00);
    check("t5_done_ign", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
